// File: rtl/reg_file_8x16_pkg.sv
// Shared constants and word/address types for the 8x16 register file.
package reg_file_8x16_pkg;

  localparam int REGF_ADDR_W = 4;
  localparam int REGF_DATA_W = 16;
  localparam int REGF_DEPTH  = 8;

  typedef logic [REGF_DATA_W-1:0] regf_data_t;
  typedef logic [REGF_ADDR_W-1:0] regf_addr_t;

endpackage

// File: rtl/reg_file_8x16.sv
// 8 x 16 register file: shared address, separate write/read enables,
// registered read port, synchronous active-high clear of all state.
module reg_file_8x16
  import reg_file_8x16_pkg::*;
#(
  parameter int ADDR_Width = REGF_ADDR_W,
  parameter int MEM_WIDTH  = REGF_DATA_W,
  parameter int MEM_DEPTH  = REGF_DEPTH
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [MEM_WIDTH-1:0]  WrData,
  input  logic [ADDR_Width-1:0] Address,
  input  logic                  WrEn,
  input  logic                  RdEn,
  output logic [MEM_WIDTH-1:0]  RdData
);

  localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  // One extra bit so the depth itself fits when it equals 2**ADDR_Width.
  localparam logic [ADDR_Width:0] DEPTH_L = MEM_DEPTH[ADDR_Width:0];

  logic [MEM_WIDTH-1:0] mem [MEM_DEPTH];
  logic                 in_range;
  logic [IDX_W-1:0]     idx;
  logic                 wr_ok;
  logic                 rd_ok;

  // Decode: no wrap-around, so out-of-range addresses never reach the array.
  always_comb begin
    in_range = ({1'b0, Address} < DEPTH_L);
    idx      = Address[IDX_W-1:0];
    wr_ok    = WrEn && !RdEn && in_range;
    rd_ok    = RdEn && !WrEn && in_range;
  end

  // Storage and read register; reset wins, both-enables reads back zero.
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < MEM_DEPTH; i++) mem[i] <= '0;
      RdData <= '0;
    end else begin
      if (wr_ok) mem[idx] <= WrData;
      if (RdEn)  RdData <= rd_ok ? mem[idx] : '0;
    end
  end

endmodule

// File: tb/tb_reg_file_8x16.sv
// Directed self-checking bench for reg_file_8x16.
module tb_reg_file_8x16;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [15:0] WrData = '0;
  logic [3:0]  Address = '0;
  logic        WrEn = 1'b0;
  logic        RdEn = 1'b0;
  logic [15:0] RdData;

  int n_checks = 0;
  int n_fail   = 0;
  logic [15:0] model [8];

  reg_file_8x16 dut (
    .CLK(CLK), .RST(RST), .WrData(WrData), .Address(Address),
    .WrEn(WrEn), .RdEn(RdEn), .RdData(RdData)
  );

  always #5 CLK = ~CLK;

  // Apply one cycle of inputs, then sample 1 time unit after the edge.
  task automatic cyc(input logic rst, input logic we, input logic re,
                     input logic [3:0] a, input logic [15:0] d);
    RST = rst; WrEn = we; RdEn = re; Address = a; WrData = d;
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    for (int i = 0; i < 8; i++) model[i] = '0;

    // Reset clear
    cyc(1, 0, 0, 4'd0, 16'h0);
    cyc(1, 0, 0, 4'd0, 16'h0);
    chk("reset_rddata", RdData, 16'h0);
    for (int i = 0; i < 8; i++) begin
      cyc(0, 0, 1, 4'(i), 16'h0);
      chk($sformatf("reset_word%0d", i), RdData, 16'h0);
    end

    // Write / read-back
    cyc(0, 1, 0, 4'd2, 16'd13); model[2] = 16'd13;
    chk("write_holds_rd", RdData, 16'h0);
    cyc(0, 1, 0, 4'd6, 16'd8);  model[6] = 16'd8;
    cyc(0, 0, 1, 4'd2, 16'h0);
    chk("read_addr2", RdData, 16'd13);

    // Idle hold with address change
    cyc(0, 0, 0, 4'd6, 16'h0);
    chk("idle_hold", RdData, 16'd13);
    cyc(0, 0, 0, 4'd6, 16'h0);
    chk("idle_hold2", RdData, 16'd13);

    cyc(0, 0, 1, 4'd6, 16'h0);
    chk("read_addr6", RdData, 16'd8);

    // Both enables: no write, RdData cleared
    cyc(0, 1, 1, 4'd3, 16'hABCD);
    chk("both_en_rd0", RdData, 16'h0);
    cyc(0, 0, 1, 4'd3, 16'h0);
    chk("both_en_nowrite", RdData, 16'h0);

    // Full-width data, read right after write
    cyc(0, 1, 0, 4'd7, 16'hA5C3); model[7] = 16'hA5C3;
    cyc(0, 0, 1, 4'd7, 16'h0);
    chk("fullwidth_addr7", RdData, 16'hA5C3);

    // Out of range write ignored, no aliasing onto addr 1
    cyc(0, 1, 0, 4'd9, 16'hFFFF);
    for (int i = 0; i < 8; i++) begin
      cyc(0, 0, 1, 4'(i), 16'h0);
      chk($sformatf("oor_word%0d", i), RdData, model[i]);
    end
    cyc(0, 0, 1, 4'd2, 16'h0);
    chk("pre_oor_read", RdData, 16'd13);
    cyc(0, 0, 1, 4'd9, 16'h0);
    chk("oor_read", RdData, 16'h0);
    cyc(0, 0, 1, 4'd15, 16'h0);
    chk("oor_read15", RdData, 16'h0);

    // Reset priority over a concurrent write
    cyc(0, 1, 0, 4'd5, 16'h1234);
    cyc(0, 0, 1, 4'd5, 16'h0);
    chk("pre_reset_addr5", RdData, 16'h1234);
    cyc(1, 1, 0, 4'd5, 16'h5555);
    chk("reset_rd_clear", RdData, 16'h0);
    cyc(0, 0, 1, 4'd5, 16'h0);
    chk("reset_prio_addr5", RdData, 16'h0);
    cyc(0, 0, 1, 4'd2, 16'h0);
    chk("reset_clears_addr2", RdData, 16'h0);

    // Reset discards a concurrent read too
    cyc(0, 1, 0, 4'd4, 16'h0F0F);
    cyc(1, 0, 1, 4'd4, 16'h0);
    chk("reset_drops_read", RdData, 16'h0);

    cyc(0, 0, 0, 4'd0, 16'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
